// File: rtl/lcd_pkg.sv
// Shared constants for the LCD frame scanner and the hd44780 driver: rs encodings,
// command bytes and the scanner state encoding.
package lcd_pkg;

  localparam logic       RS_CMD        = 1'b0;
  localparam logic       RS_DATA       = 1'b1;
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] CHAR_BLANK    = 8'h20;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StChar
  } scan_state_e;

endpackage

// File: rtl/lcd_char_buf.sv
// Character frame buffer: DEPTH x 8 register file, async reset to blanks,
// one synchronous write port and one combinational read port.
module lcd_char_buf
  import lcd_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_q [DEPTH];

  // Storage; out-of-range writes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= CHAR_BLANK;
      end
    end else if (wr_en && (32'(wr_addr) < DEPTH)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read port; addresses past the end read as blank.
  always_comb begin
    rd_data = CHAR_BLANK;
    if (32'(rd_addr) < DEPTH) begin
      rd_data = mem_q[rd_addr];
    end
  end

endmodule

// File: rtl/lcd_frame_scanner.sv
// Streams a 2-row character frame buffer to the hd44780 driver as (rs, byte) beats
// over a valid/ready handshake. Optional feature macro: LCD_DIRTY_REFRESH_EN
// (refresh only after a write instead of continuously).
module lcd_frame_scanner
  import lcd_pkg::*;
#(
  parameter int unsigned COLS      = 16,
  parameter logic [7:0]  ROW0_BASE = 8'h00,
  parameter logic [7:0]  ROW1_BASE = 8'h40,
  localparam int unsigned AW       = $clog2(2 * COLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic          out_valid,
  output logic          out_rs,
  output logic [7:0]    out_data,
  input  logic          out_ready,
  output logic          frame_done
);

  localparam int unsigned CW       = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [AW-1:0] ROW1_IDX = AW'(COLS);

  scan_state_e   state_q, state_d;
  logic          row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          valid_q, valid_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          xfer;
  logic          start;

  lcd_char_buf #(
    .DEPTH (2 * COLS),
    .AW    (AW)
  ) u_char_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign xfer = valid_q && out_ready;

  // Index of the char that would be loaded on the next transfer.
  assign rd_addr = (row_q ? ROW1_IDX : '0) +
                   ((state_q == StChar) ? (AW'(col_q) + AW'(1)) : '0);

`ifdef LCD_DIRTY_REFRESH_EN
  logic dirty_q;
  logic wr_hit;

  assign wr_hit = wr_en && (32'(wr_addr) < 2 * COLS);
  assign start  = enable && dirty_q;

  // Dirty flag; a write wins over the frame-start clear so it is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dirty_q <= 1'b1;
    end else if (wr_hit) begin
      dirty_q <= 1'b1;
    end else if ((state_q == StIdle) && start) begin
      dirty_q <= 1'b0;
    end
  end
`else
  assign start = enable;
`endif

  // State, counters and output beat register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      row_q   <= 1'b0;
      col_q   <= '0;
      valid_q <= 1'b0;
      rs_q    <= RS_CMD;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      valid_q <= valid_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
    end
  end

  // Next state; the next beat is loaded on the transfer edge so beats can go back-to-back.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    valid_d = valid_q;
    rs_d    = rs_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAddr;
          row_d   = 1'b0;
          col_d   = '0;
          valid_d = 1'b1;
          rs_d    = RS_CMD;
          data_d  = CMD_SET_DDRAM | ROW0_BASE;
        end
      end
      StAddr: begin
        if (xfer) begin
          state_d = StChar;
          col_d   = '0;
          rs_d    = RS_DATA;
          data_d  = rd_data;
        end
      end
      StChar: begin
        if (xfer) begin
          if (col_q != COL_LAST) begin
            col_d  = col_q + 1'b1;
            rs_d   = RS_DATA;
            data_d = rd_data;
          end else if (!row_q) begin
            state_d = StAddr;
            row_d   = 1'b1;
            rs_d    = RS_CMD;
            data_d  = CMD_SET_DDRAM | ROW1_BASE;
          end else begin
            state_d = StIdle;
            row_d   = 1'b0;
            col_d   = '0;
            valid_d = 1'b0;
            rs_d    = RS_CMD;
            data_d  = 8'h00;
          end
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
  end

  // Outputs; frame_done marks acceptance of the last char of row 1.
  always_comb begin
    out_valid  = valid_q;
    out_rs     = rs_q;
    out_data   = data_q;
    frame_done = xfer && (state_q == StChar) && row_q && (col_q == COL_LAST);
  end

endmodule
